// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared op encodings, FSM states and geometry helpers for cache_ctrl_dm
package cache_pkg;

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_NOP = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_WR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FILL,
        S_CLEAR,
        S_DONE
    } state_t;

    function automatic int lines_of(input int index_w);
        return 1 << index_w;
    endfunction

    function automatic int tag_w_of(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - tag/data/valid/dirty arrays, async read, sync write, async valid clear
module cache_line_store
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 3,
    localparam int TAG_W  = tag_w_of(ADDR_W, INDEX_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               line_we,
    input  logic               meta_we,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_valid,
    input  logic               wr_dirty
);

    localparam int LINES = lines_of(INDEX_W);

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_data  = data_mem[idx];

    // line_we rewrites the whole line; meta_we touches only the state bits
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (line_we || meta_we) begin
            valid_d[idx] = wr_valid;
            dirty_d[idx] = wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[idx]  <= wr_tag;
            data_mem[idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

endmodule

// File: rtl/cache_ctrl_dm.sv
// rtl/cache_ctrl_dm.sv - direct-mapped write-back cache FSM with indirect access; CACHE_CTRL_STATS_EN adds hit/miss counters
module cache_ctrl_dm
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_op,
    input  logic              cpu_ind,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses
`endif
);

    localparam int LINES = lines_of(INDEX_W);
    localparam int TAG_W = tag_w_of(ADDR_W, INDEX_W);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(LINES - 1);

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                ind_q, ind_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [INDEX_W-1:0]  clr_idx_q, clr_idx_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                cpu_done_q, cpu_done_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
`ifdef CACHE_CTRL_STATS_EN
    logic                retry_q, retry_d;
    logic [15:0]         hits_q, hits_d;
    logic [15:0]         misses_q, misses_d;
`endif

    logic [INDEX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]    addr_tag;
    logic                rd_valid, rd_dirty, hit;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                line_we, meta_we, ls_valid, ls_dirty;
    logic [TAG_W-1:0]    ls_tag;
    logic [DATA_W-1:0]   ls_data;

    // The clear walk addresses the arrays by its own counter, everything else by the request address
    assign cur_idx  = (op_q == OP_CLR) ? clr_idx_q : addr_q[INDEX_W-1:0];
    assign addr_tag = addr_q[ADDR_W-1:INDEX_W];
    assign hit      = rd_valid && (rd_tag == addr_tag);

    cache_line_store #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx      (cur_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .line_we  (line_we),
        .meta_we  (meta_we),
        .wr_tag   (ls_tag),
        .wr_data  (ls_data),
        .wr_valid (ls_valid),
        .wr_dirty (ls_dirty)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ind_d       = ind_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        clr_idx_d   = clr_idx_q;
        cpu_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_we     = 1'b0;
        meta_we     = 1'b0;
        ls_tag      = addr_tag;
        ls_data     = wdata_q;
        ls_valid    = 1'b1;
        ls_dirty    = 1'b0;
`ifdef CACHE_CTRL_STATS_EN
        retry_d     = retry_q;
        hits_d      = hits_q;
        misses_d    = misses_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_req && cpu_ready_q) begin
                    op_d    = cpu_op;
                    ind_d   = cpu_ind;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    if (cpu_op == OP_NOP) begin
                        state_d    = S_DONE;
                        cpu_done_d = 1'b1;
                    end else if (cpu_op == OP_CLR) begin
                        state_d   = S_CLEAR;
                        clr_idx_d = '0;
`ifdef CACHE_CTRL_STATS_EN
                        hits_d    = '0;
                        misses_d  = '0;
`endif
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
`ifdef CACHE_CTRL_STATS_EN
                retry_d = 1'b0;
                if (!retry_q) begin
                    if (hit) hits_d = (hits_q == 16'hFFFF) ? hits_q : hits_q + 16'd1;
                    else     misses_d = (misses_q == 16'hFFFF) ? misses_q : misses_q + 16'd1;
                end
`endif
                if (hit) begin
                    if (ind_q) begin
                        addr_d = rd_data[ADDR_W-1:0];
                        ind_d  = 1'b0;
                    end else if (op_q == OP_RD) begin
                        cpu_rdata_d = rd_data;
                        state_d     = S_DONE;
                        cpu_done_d  = 1'b1;
                    end else begin
                        line_we    = 1'b1;
                        ls_dirty   = 1'b1;
                        state_d    = S_DONE;
                        cpu_done_d = 1'b1;
                    end
                end else if (rd_valid && rd_dirty) begin
                    state_d     = S_WRITEBACK;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = {rd_tag, cur_idx};
                    mem_wdata_d = rd_data;
                end else begin
                    state_d    = S_FILL;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr_q;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack) begin
                    mem_wr_d = 1'b0;
                    meta_we  = 1'b1;
                    if (op_q == OP_CLR) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d    = S_FILL;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = addr_q;
                    end
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    mem_rd_d = 1'b0;
                    line_we  = 1'b1;
                    ls_data  = mem_rdata;
                    state_d  = S_LOOKUP;
`ifdef CACHE_CTRL_STATS_EN
                    retry_d  = 1'b1;
`endif
                end
            end
            S_CLEAR: begin
                // Dirty lines detour through WRITEBACK and come back to the same index
                if (rd_valid && rd_dirty) begin
                    state_d     = S_WRITEBACK;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = {rd_tag, cur_idx};
                    mem_wdata_d = rd_data;
                end else begin
                    meta_we  = 1'b1;
                    ls_valid = 1'b0;
                    if (clr_idx_q == LAST_IDX) begin
                        state_d    = S_DONE;
                        cpu_done_d = 1'b1;
                    end else begin
                        clr_idx_d = clr_idx_q + 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cpu_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_CLR;
            ind_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            clr_idx_q   <= '0;
            cpu_ready_q <= 1'b1;
            cpu_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef CACHE_CTRL_STATS_EN
            retry_q     <= 1'b0;
            hits_q      <= '0;
            misses_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ind_q       <= ind_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            clr_idx_q   <= clr_idx_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_done_q  <= cpu_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef CACHE_CTRL_STATS_EN
            retry_q     <= retry_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
`endif
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef CACHE_CTRL_STATS_EN
    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// tb/tb_cache_ctrl_dm.sv - scoreboard bench for cache_ctrl_dm with a delayed-ack RAM model
module tb_cache_ctrl_dm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_req = 1'b0;
    logic [1:0] cpu_op = 2'b01;
    logic       cpu_ind = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ready, cpu_done;
    logic [7:0] cpu_rdata;
    logic       mem_rd, mem_wr;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       mem_ack = 1'b0;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] stat_hits, stat_misses;
`endif

    always #5 clk = ~clk;

    cache_ctrl_dm #(.ADDR_W(8), .DATA_W(8), .INDEX_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_op    (cpu_op),
        .cpu_ind   (cpu_ind),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } mem_exp_t;

    typedef struct {
        bit         chk;
        logic [7:0] data;
    } done_exp_t;

    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];
    logic [7:0] ram [0:255];
    int n_cmp = 0;
    int n_err = 0;
    int ack_delay = 0;
    int n_rd = 0;
    int n_wr = 0;

    // RAM model: checks each new request against mem_q, holds it, acks after ack_delay cycles
    initial begin : responder
        bit         pending;
        int         wcnt;
        logic       cur_wr;
        logic [7:0] cur_addr, cur_wdata;
        mem_exp_t   e;
        pending = 1'b0;
        wcnt = 0;
        cur_wr = 1'b0;
        cur_addr = '0;
        cur_wdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                pending = 1'b0;
            end
            if (!rst_n || !(mem_rd || mem_wr)) begin
                pending = 1'b0;
            end else begin
                n_cmp++;
                if (mem_rd && mem_wr) begin
                    n_err++;
                    $display("FAIL mem_exclusive: rd=%b wr=%b, required not both", mem_rd, mem_wr);
                end
                if (!pending) begin
                    pending = 1'b1;
                    wcnt = 0;
                    cur_wr = mem_wr;
                    cur_addr = mem_addr;
                    cur_wdata = mem_wdata;
                    if (cur_wr) n_wr++; else n_rd++;
                    n_cmp++;
                    if (mem_q.size() == 0) begin
                        n_err++;
                        $display("FAIL mem_unexpected: wr=%b addr=%h data=%h, required no request", cur_wr, cur_addr, cur_wdata);
                    end else begin
                        e = mem_q.pop_front();
                        if (e.wr !== cur_wr || e.addr !== cur_addr || (e.wr && e.data !== cur_wdata)) begin
                            n_err++;
                            $display("FAIL mem_request: got wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                                     cur_wr, cur_addr, cur_wdata, e.wr, e.addr, e.data);
                        end
                    end
                    if (cur_wr) ram[cur_addr] = cur_wdata;
                end else begin
                    n_cmp++;
                    if (mem_wr !== cur_wr || mem_addr !== cur_addr || mem_wdata !== cur_wdata) begin
                        n_err++;
                        $display("FAIL mem_stable: got wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                                 mem_wr, mem_addr, mem_wdata, cur_wr, cur_addr, cur_wdata);
                    end
                end
                if (wcnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = ram[cur_addr];
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Completion scoreboard: each cpu_done pops one expected result
    initial begin : done_monitor
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (rst_n && cpu_done) begin
                n_cmp++;
                if (done_q.size() == 0) begin
                    n_err++;
                    $display("FAIL done_unexpected: cpu_done=1, required 0");
                end else begin
                    d = done_q.pop_front();
                    if (d.chk && cpu_rdata !== d.data) begin
                        n_err++;
                        $display("FAIL rdata: got %h, required %h", cpu_rdata, d.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_op(input logic [1:0] op, input logic ind, input logic [7:0] addr,
                            input logic [7:0] wdata, input bit chk, input logic [7:0] exp, output int lat);
        done_exp_t d;
        d.chk = chk;
        d.data = exp;
        done_q.push_back(d);
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_op = op;
        cpu_ind = ind;
        cpu_addr = addr;
        cpu_wdata = wdata;
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            lat++;
            if (cpu_done) break;
        end
        if (!cpu_done) lat = -1;
    endtask

    task automatic push_mem(input bit wr, input logic [7:0] addr, input logic [7:0] data);
        mem_exp_t e;
        e.wr = wr;
        e.addr = addr;
        e.data = data;
        mem_q.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cpu_ready !== 1'b1 || cpu_done !== 1'b0 || cpu_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_cpu: ready=%b done=%b rdata=%h, required 1 0 00", cpu_ready, cpu_done, cpu_rdata);
        end
        n_cmp++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mem: rd=%b wr=%b addr=%h wdata=%h, required 0 0 00 00", mem_rd, mem_wr, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_nop_and_clean_clear;
        int lat;
        drive_op(2'b01, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, lat);
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL nop_latency: got %0d, required 1", lat); end
        drive_op(2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, lat);
        n_cmp++;
        if (lat !== 9) begin n_err++; $display("FAIL clean_clear_latency: got %0d, required 9", lat); end
    endtask

    task automatic test_read_miss_hit;
        int lat, rd0;
        ram[8'h25] = 8'h5A;
        push_mem(1'b0, 8'h25, 8'h00);
        drive_op(2'b10, 1'b0, 8'h25, 8'h00, 1'b1, 8'h5A, lat);
        n_cmp++;
        if (lat !== 4) begin n_err++; $display("FAIL miss_latency: got %0d, required 4", lat); end
        rd0 = n_rd;
        drive_op(2'b10, 1'b0, 8'h25, 8'h00, 1'b1, 8'h5A, lat);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL hit_latency: got %0d, required 2", lat); end
        n_cmp++;
        if (n_rd !== rd0) begin n_err++; $display("FAIL hit_no_mem_rd: got %0d reads, required %0d", n_rd, rd0); end
        n_cmp++;
        if (mem_q.size() !== 0) begin n_err++; $display("FAIL read_mem_pending: got %0d, required 0", mem_q.size()); end
    endtask

    task automatic test_writeback;
        int lat;
        ram[8'h05] = 8'h77;
        ram[8'h0D] = 8'h3C;
        push_mem(1'b0, 8'h05, 8'h00);
        drive_op(2'b11, 1'b0, 8'h05, 8'h11, 1'b0, 8'h00, lat);
        push_mem(1'b1, 8'h05, 8'h11);
        push_mem(1'b0, 8'h0D, 8'h00);
        drive_op(2'b10, 1'b0, 8'h0D, 8'h00, 1'b1, 8'h3C, lat);
        n_cmp++;
        if (lat < 0 || mem_q.size() !== 0) begin
            n_err++;
            $display("FAIL writeback_seq: lat=%0d pending=%0d, required done with 0 pending", lat, mem_q.size());
        end
    endtask

    task automatic test_indirect;
        int lat;
        ram[8'h03] = 8'h40;
        ram[8'h40] = 8'h99;
        push_mem(1'b0, 8'h03, 8'h00);
        push_mem(1'b0, 8'h40, 8'h00);
        drive_op(2'b10, 1'b1, 8'h03, 8'h00, 1'b1, 8'h99, lat);
        n_cmp++;
        if (lat < 0 || mem_q.size() !== 0) begin
            n_err++;
            $display("FAIL indirect_fills: lat=%0d pending=%0d, required done with 0 pending", lat, mem_q.size());
        end
    endtask

    task automatic test_clear_dirty;
        int lat, wr0;
        push_mem(1'b0, 8'h02, 8'h00);
        drive_op(2'b11, 1'b0, 8'h02, 8'hA2, 1'b0, 8'h00, lat);
        push_mem(1'b0, 8'h36, 8'h00);
        drive_op(2'b11, 1'b0, 8'h36, 8'hB6, 1'b0, 8'h00, lat);
        wr0 = n_wr;
        push_mem(1'b1, 8'h02, 8'hA2);
        push_mem(1'b1, 8'h36, 8'hB6);
        drive_op(2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, lat);
        n_cmp++;
        if (n_wr - wr0 !== 2) begin n_err++; $display("FAIL clear_writebacks: got %0d, required 2", n_wr - wr0); end
        push_mem(1'b0, 8'h03, 8'h00);
        drive_op(2'b10, 1'b0, 8'h03, 8'h00, 1'b1, 8'h40, lat);
        n_cmp++;
        if (mem_q.size() !== 0) begin n_err++; $display("FAIL clear_then_miss: pending %0d, required 0", mem_q.size()); end
    endtask

    task automatic test_back_to_back;
        int lat;
        ack_delay = 5;
        ram[8'h80] = 8'hC3;
        push_mem(1'b0, 8'h80, 8'h00);
        drive_op(2'b10, 1'b0, 8'h80, 8'h00, 1'b1, 8'hC3, lat);
        n_cmp++;
        if (lat !== 9) begin n_err++; $display("FAIL delayed_miss_latency: got %0d, required 9", lat); end
        drive_op(2'b11, 1'b0, 8'h80, 8'h5E, 1'b0, 8'h00, lat);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL write_hit_latency: got %0d, required 2", lat); end
        drive_op(2'b10, 1'b0, 8'h80, 8'h00, 1'b1, 8'h5E, lat);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL read_after_write_latency: got %0d, required 2", lat); end
    endtask

    task automatic test_reset_mid_wait;
        int lat;
        ack_delay = 1000;
        push_mem(1'b0, 8'h89, 8'h00);
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_op = 2'b10;
        cpu_ind = 1'b0;
        cpu_addr = 8'h89;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h89) begin
            n_err++;
            $display("FAIL wait_request: rd=%b addr=%h, required 1 89", mem_rd, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cpu_ready !== 1'b1 || cpu_done !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 8'h00 || cpu_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: ready=%b done=%b rd=%b wr=%b addr=%h rdata=%h, required 1 0 0 0 00 00",
                     cpu_ready, cpu_done, mem_rd, mem_wr, mem_addr, cpu_rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        mem_q.delete();
        done_q.delete();
        push_mem(1'b0, 8'h80, 8'h00);
        drive_op(2'b10, 1'b0, 8'h80, 8'h00, 1'b1, 8'hC3, lat);
        n_cmp++;
        if (lat < 0 || mem_q.size() !== 0) begin
            n_err++;
            $display("FAIL post_reset_miss: lat=%0d pending=%0d, required done with 0 pending", lat, mem_q.size());
        end
    endtask

`ifdef CACHE_CTRL_STATS_EN
    task automatic test_stats;
        int lat;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ram[8'h25] = 8'h5A;
        push_mem(1'b0, 8'h25, 8'h00);
        drive_op(2'b10, 1'b0, 8'h25, 8'h00, 1'b1, 8'h5A, lat);
        drive_op(2'b10, 1'b0, 8'h25, 8'h00, 1'b1, 8'h5A, lat);
        n_cmp++;
        if (stat_misses !== 16'd1 || stat_hits !== 16'd1) begin
            n_err++;
            $display("FAIL stats: hits=%0d misses=%0d, required 1 1", stat_hits, stat_misses);
        end
        drive_op(2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, lat);
        n_cmp++;
        if (stat_misses !== 16'd0 || stat_hits !== 16'd0) begin
            n_err++;
            $display("FAIL stats_clear: hits=%0d misses=%0d, required 0 0", stat_hits, stat_misses);
        end
    endtask
`endif

    initial begin : main
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
        repeat (2) @(negedge clk);
        test_reset();
        test_nop_and_clean_clear();
        test_read_miss_hit();
        test_writeback();
        test_indirect();
        test_clear_dirty();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef CACHE_CTRL_STATS_EN
        test_stats();
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mem_q.size() !== 0 || done_q.size() !== 0) begin
            n_err++;
            $display("FAIL final_queues: mem=%0d done=%0d, required 0 0", mem_q.size(), done_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
